gst_dmasnd_engine: RTL
======================

Name: gst_dmasnd_engine

Overview:
Parametrised successor to the STE DMA sound playback path. It buffers DMA-fetched 16-bit words in a true-full FIFO with a programmable request watermark, and generates the 50/25/12.5/6.25 kHz sample tick. It plays 8-bit stereo, 8-bit mono, 16-bit stereo and 16-bit mono, and reports underrun and overflow. It sits between the MCU DMA sound fetch (SLOAD_N/SREQ) and the audio mixer.

Parameters:
FIFO_ADDR_BITS, 3, log2 of FIFO depth; DEPTH = 2^FIFO_ADDR_BITS words.
REQ_FREE, 2, SREQ is asserted while free entries >= REQ_FREE; legal range 1..DEPTH.
CLK_DIV, 640, clk32 cycles per 50 kHz base tick.
AUDIO_W, 16, output sample width; must be >= 8.

Ports:
clk32  in  1  system clock, 32 MHz
resb  in  1  asynchronous active-low reset
mode  in  4  [1:0] rate (11=50k, 10=25k, 01=12.5k, 00=6.25k); [2] mono; [3] 16-bit samples
flush  in  1  synchronous FIFO clear, one cycle
SLOAD_N  in  1  DMA load strobe; falling edge writes MDIN
MDIN  in  16  RAM data
SREQ  out  1  DMA request
audio_left  out  AUDIO_W  unsigned left sample
audio_right  out  AUDIO_W  unsigned right sample
sample_tick  out  1  one-cycle pulse on each output update or underrun
underrun  out  1  one-cycle pulse when a tick finds insufficient data
overflow  out  1  sticky; set on write to a full FIFO, cleared by flush
level  out  FIFO_ADDR_BITS+1  words currently stored

Behaviour:
- Reset (resb=0, async): pointers, level, and all counters = 0; sload_d=1; bytesel=0; audio_left/right = 2^(AUDIO_W-1) (midpoint); sample_tick, underrun, overflow = 0.
- Base divider counts 0..CLK_DIV-1 and wraps. base_en is registered and high when the count is 0.
- aclk_cnt (3 bits) increments on base_en. aclk_en is registered one cycle after base_en, gated per rate: 50k every base_en; 25k when aclk_cnt[0]=0; 12.5k when [1:0]=0; 6.25k when [2:0]=0.
- Write: a write occurs at the edge where sload_d=1 and SLOAD_N=0. MDIN is stored at writeP and writeP increments (wraps at DEPTH). If level==DEPTH, the word is dropped and overflow is set.
- FIFO is true-full: level reaches DEPTH. Simultaneous write and read in one cycle: level += 1 - words_consumed.
- SREQ = (DEPTH - level) >= REQ_FREE, combinational from level.
- Words needed per aclk_en:
  - 16-bit stereo: 2 (fifo[readP] = left, fifo[readP+1] = right).
  - 16-bit mono: 1, sent to both channels.
  - 8-bit stereo: 1 ([15:8] left, [7:0] right).
  - 8-bit mono: [15:8] when bytesel=0, else [7:0], sent to both channels. Toggles bytesel; the word is consumed only when bytesel was 1.
- Sample conversion: sign-flip (invert MSB). 8-bit samples are left-justified, with low AUDIO_W-8 bits zero. 16-bit samples are truncated/left-justified to AUDIO_W.
- Output latency: outputs change on the clk32 edge where aclk_en=1; sample_tick pulses in the same cycle.
- Underrun: on aclk_en with level < words needed:
  - outputs hold, no pointer or bytesel change;
  - underrun and sample_tick pulse.
  - A read in the same cycle as a write sees only the pre-write level.
- flush: readP=writeP=level=0, bytesel=0, overflow=0; outputs hold. flush wins over a simultaneous write/read.
- Mode change takes effect at the next aclk_en. bytesel is not cleared on mode change.
- Reset mid-stream discards all FIFO content; FIFO RAM contents are not reset.

Optional Feature:
DMASND_UNDERRUN_CNT_EN
- Defined: adds output underrun_cnt [7:0], a saturating count of underrun pulses (stays at 255), cleared by reset and flush.
- Undefined: port and counter are absent; no other behaviour changes.

Test Plan:
1. Reset; no loads -> SREQ=1, level=0, audio_left/right=16'h8000, and at each aclk_en, underrun=1 with outputs held.
2. Defaults, 5 writes, 50k 8-bit stereo, first word 16'h7F80 -> first tick left=16'hFF00, right=16'h0000; level 5->4.
3. Fill to 8 words -> SREQ falls at level 7 (free 1 < 2); 9th load -> dropped, overflow=1, level stays 8; flush -> level=0, overflow=0.
4. 8-bit mono, 2 words 16'h0102, 16'h0304 -> ticks give both channels 16'h8100, 16'h8200, 16'h8300, 16'h8400; level decrements only on ticks 2 and 4.
5. 16-bit stereo with 1 word only -> underrun, nothing consumed; after a 2nd word (16'h1234, 16'h0000) -> left=16'h9234, right=16'h8000, level 2->0.
6. Rate 00 -> sample_tick spacing exactly 8*640=5120 clk32 cycles; write and read in the same cycle -> level unchanged.

Source files
------------

// File: rtl/gst_dmasnd_engine.sv
// DMA sound playback engine: true-full word FIFO, sample-rate tick and 8/16-bit stereo/mono unpack.
// Optional DMASND_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module gst_dmasnd_engine #(
   parameter int unsigned FIFO_ADDR_BITS = 3,
   parameter int unsigned REQ_FREE       = 2,
   parameter int unsigned CLK_DIV        = 640,
   parameter int unsigned AUDIO_W        = 16
) (
   input  logic                      clk32,
   input  logic                      resb,
   input  logic [3:0]                mode,
   input  logic                      flush,
   input  logic                      SLOAD_N,
   input  logic [15:0]               MDIN,
   output logic                      SREQ,
   output logic [AUDIO_W-1:0]        audio_left,
   output logic [AUDIO_W-1:0]        audio_right,
   output logic                      sample_tick,
   output logic                      underrun,
   output logic                      overflow,
   output logic [FIFO_ADDR_BITS:0]   level
`ifdef DMASND_UNDERRUN_CNT_EN
   ,
   output logic [7:0]                underrun_cnt
`endif
);

   localparam int unsigned DEPTH = 2 ** FIFO_ADDR_BITS;
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned LW    = FIFO_ADDR_BITS + 1;

   typedef logic [FIFO_ADDR_BITS-1:0] ptr_t;

   logic [DIV_W-1:0]   div_cnt_q;
   logic               base_en_q;
   logic [2:0]         aclk_cnt_q;
   logic               aclk_en_q;
   logic               rate_ok;
   logic               sload_q;
   ptr_t               wr_ptr_q, rd_ptr_q;
   logic               bytesel_q, bytesel_d;
   logic [LW-1:0]      level_q, level_d;
   logic [15:0]        fifo [DEPTH];
   logic [15:0]        word0, word1;
   logic [LW-1:0]      need, consume;
   logic [AUDIO_W-1:0] left_d, right_d;
   logic [7:0]         sel_byte;
   logic               do_tick, starved, do_read, wr_req, full, do_write;

   // Sign-flip and left-justify a 16-bit sample into AUDIO_W bits.
   function automatic logic [AUDIO_W-1:0] conv(input logic [15:0] s);
      logic [AUDIO_W+15:0] w;
      w = {~s[15], s[14:0], {AUDIO_W{1'b0}}};
      return AUDIO_W'(w >> 16);
   endfunction

   always_comb begin
      rate_ok = 1'b0;
      unique case (mode[1:0])
         2'b11: rate_ok = 1'b1;
         2'b10: rate_ok = ~aclk_cnt_q[0];
         2'b01: rate_ok = (aclk_cnt_q[1:0] == 2'b00);
         2'b00: rate_ok = (aclk_cnt_q == 3'b000);
      endcase
   end

   always_ff @(posedge clk32 or negedge resb) begin
      if (!resb) begin
         div_cnt_q  <= '0;
         base_en_q  <= 1'b0;
         aclk_cnt_q <= '0;
         aclk_en_q  <= 1'b0;
         sload_q    <= 1'b1;
      end else begin
         div_cnt_q  <= (div_cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
         base_en_q  <= (div_cnt_q == '0);
         if (base_en_q) aclk_cnt_q <= aclk_cnt_q + 3'd1;
         // Gate uses the pre-increment count so every rate ticks on aclk_cnt == 0.
         aclk_en_q  <= base_en_q & rate_ok;
         sload_q    <= SLOAD_N;
      end
   end

   assign word0    = fifo[rd_ptr_q];
   assign word1    = fifo[ptr_t'(rd_ptr_q + ptr_t'(1))];
   assign sel_byte = bytesel_q ? word0[7:0] : word0[15:8];

   always_comb begin
      need      = LW'(1);
      consume   = LW'(1);
      left_d    = audio_left;
      right_d   = audio_right;
      bytesel_d = bytesel_q;
      unique case (mode[3:2])
         2'b10: begin
            need    = LW'(2);
            consume = LW'(2);
            left_d  = conv(word0);
            right_d = conv(word1);
         end
         2'b11: begin
            left_d  = conv(word0);
            right_d = conv(word0);
         end
         2'b00: begin
            left_d  = conv({word0[15:8], 8'h00});
            right_d = conv({word0[7:0], 8'h00});
         end
         2'b01: begin
            // Mono 8-bit plays the high byte first; the word retires after the low byte.
            left_d    = conv({sel_byte, 8'h00});
            right_d   = conv({sel_byte, 8'h00});
            consume   = bytesel_q ? LW'(1) : LW'(0);
            bytesel_d = ~bytesel_q;
         end
      endcase
   end

   assign do_tick  = aclk_en_q & ~flush;
   assign starved  = (level_q < need);
   assign do_read  = do_tick & ~starved;
   assign wr_req   = sload_q & ~SLOAD_N;
   assign full     = (level_q == LW'(DEPTH));
   assign do_write = wr_req & ~full & ~flush;
   assign level_d  = level_q + (do_write ? LW'(1) : LW'(0)) - (do_read ? consume : LW'(0));

   assign level = level_q;
   assign SREQ  = ((LW'(DEPTH) - level_q) >= LW'(REQ_FREE));

   always_ff @(posedge clk32) begin
      if (do_write) fifo[wr_ptr_q] <= MDIN;
   end

   always_ff @(posedge clk32 or negedge resb) begin
      if (!resb) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         bytesel_q   <= 1'b0;
         overflow    <= 1'b0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
         audio_left  <= {1'b1, {(AUDIO_W-1){1'b0}}};
         audio_right <= {1'b1, {(AUDIO_W-1){1'b0}}};
      end else begin
         sample_tick <= do_tick;
         underrun    <= do_tick & starved;
         if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            bytesel_q <= 1'b0;
            overflow  <= 1'b0;
         end else begin
            level_q <= level_d;
            if (do_write) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (wr_req && full) overflow <= 1'b1;
            if (do_read) begin
               rd_ptr_q    <= rd_ptr_q + ptr_t'(consume);
               bytesel_q   <= bytesel_d;
               audio_left  <= left_d;
               audio_right <= right_d;
            end
         end
      end
   end

`ifdef DMASND_UNDERRUN_CNT_EN
   always_ff @(posedge clk32 or negedge resb) begin
      if (!resb) begin
         underrun_cnt <= '0;
      end else if (flush) begin
         underrun_cnt <= '0;
      end else if (do_tick && starved && underrun_cnt != 8'hFF) begin
         underrun_cnt <= underrun_cnt + 8'd1;
      end
   end
`endif

endmodule
